// File: rtl/dsm_dec_pkg.sv
// Shared constants, byte-slot decoding and output saturation for the
// delta-sigma sinc3 decimation filter.
package dsm_dec_pkg;

  localparam int R          = 256;
  localparam int LOG2R      = $clog2(R);
  localparam int ORDER      = 3;
  localparam int W          = ORDER * LOG2R + 1;
  localparam int OUT_W      = 24;

  // Phase only needs to distinguish the slots up to the LSB byte.
  localparam int PH_W       = 6;
  localparam int STROBE_LEN = 8;
  localparam int MSB_END    = 39;
  localparam int MID_END    = 55;

  typedef enum logic [1:0] {
    SLOT_MSB = 2'd0,
    SLOT_MID = 2'd1,
    SLOT_LSB = 2'd2
  } byte_slot_e;

  // Full-scale input gives exactly 2^OUT_W, which does not fit the code width.
  function automatic logic [OUT_W-1:0] sat_code(input logic [W-1:0] value);
    logic [OUT_W-1:0] code;
    if (|value[W-1:OUT_W]) begin
      code = {OUT_W{1'b1}};
    end else begin
      code = value[OUT_W-1:0];
    end
    return code;
  endfunction

  function automatic byte_slot_e slot_of(input logic [PH_W-1:0] phase);
    byte_slot_e slot;
    if (phase <= PH_W'(MSB_END)) begin
      slot = SLOT_MSB;
    end else if (phase <= PH_W'(MID_END)) begin
      slot = SLOT_MID;
    end else begin
      slot = SLOT_LSB;
    end
    return slot;
  endfunction

endpackage

// File: rtl/cic_sinc3_decim.sv
// Third-order CIC decimator: three wrap-around integrators at the input rate,
// three combs evaluated once per decimation period.
module cic_sinc3_decim
  import dsm_dec_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic [OUT_W-1:0] word,
  output logic             word_valid
);

  logic [W-1:0]     integ1_r;
  logic [W-1:0]     integ2_r;
  logic [W-1:0]     integ3_r;
  logic [W-1:0]     dly1_r;
  logic [W-1:0]     dly2_r;
  logic [W-1:0]     dly3_r;
  logic [W-1:0]     comb1_s;
  logic [W-1:0]     comb2_s;
  logic [W-1:0]     comb3_s;
  logic [LOG2R-1:0] dec_cnt_r;
  logic             wrap_s;

  // Combs are combinational so the top can capture the result on the wrap edge itself.
  always_comb begin
    wrap_s  = (dec_cnt_r == LOG2R'(R - 1));
    comb1_s = integ3_r - dly1_r;
    comb2_s = comb1_s - dly2_r;
    comb3_s = comb2_s - dly3_r;
  end

  // Integrator cascade and decimation counter, running every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ1_r  <= {W{1'b0}};
      integ2_r  <= {W{1'b0}};
      integ3_r  <= {W{1'b0}};
      dec_cnt_r <= {LOG2R{1'b0}};
    end else begin
      integ1_r  <= integ1_r + {{(W-1){1'b0}}, din};
      integ2_r  <= integ2_r + integ1_r;
      integ3_r  <= integ3_r + integ2_r;
      dec_cnt_r <= dec_cnt_r + LOG2R'(1);
    end
  end

  // Comb delay lines advance only at the decimated rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly1_r <= {W{1'b0}};
      dly2_r <= {W{1'b0}};
      dly3_r <= {W{1'b0}};
    end else if (wrap_s) begin
      dly1_r <= integ3_r;
      dly2_r <= comb1_s;
      dly3_r <= comb2_s;
    end else begin
      dly1_r <= dly1_r;
      dly2_r <= dly2_r;
      dly3_r <= dly3_r;
    end
  end

  assign word       = sat_code(comb3_s);
  assign word_valid = wrap_s;

endmodule

// File: rtl/dsm_decimation_filter.sv
// TinyTapeout tile: sinc3 decimation of the DSM bitstream on ui_in[0], with each
// 24-bit code framed by a strobe on uio_out[2] and sent MSB byte first on uo_out.
module dsm_decimation_filter
  import dsm_dec_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [OUT_W-1:0] cic_word_s;
  logic             cic_valid_s;
  logic [OUT_W-1:0] word_r;
  logic [OUT_W-1:0] word_next_s;
  logic [PH_W-1:0]  phase_r;
  logic [PH_W-1:0]  phase_next_s;
  logic             started_r;
  logic             started_next_s;
  logic             strobe_r;
  logic             strobe_next_s;
  logic [7:0]       byte_r;
  logic [7:0]       byte_next_s;
  logic             unused_s;

  cic_sinc3_decim u_cic (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (ui_in[0]),
    .word       (cic_word_s),
    .word_valid (cic_valid_s)
  );

  // Next frame state; outputs are decoded from it so the pins come straight from flops.
  always_comb begin
    word_next_s    = word_r;
    phase_next_s   = phase_r;
    started_next_s = started_r | cic_valid_s;
    byte_next_s    = 8'h00;
    if (cic_valid_s) begin
      word_next_s  = cic_word_s;
      phase_next_s = {PH_W{1'b0}};
    end else if (phase_r != {PH_W{1'b1}}) begin
      phase_next_s = phase_r + PH_W'(1);
    end else begin
      phase_next_s = phase_r;
    end
    strobe_next_s = started_next_s && (phase_next_s < PH_W'(STROBE_LEN));
    case (slot_of(phase_next_s))
      SLOT_MSB: byte_next_s = word_next_s[23:16];
      SLOT_MID: byte_next_s = word_next_s[15:8];
      SLOT_LSB: byte_next_s = word_next_s[7:0];
      default:  byte_next_s = 8'h00;
    endcase
  end

  // Output word, frame phase and registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r    <= {OUT_W{1'b0}};
      phase_r   <= {PH_W{1'b0}};
      started_r <= 1'b0;
      strobe_r  <= 1'b0;
      byte_r    <= 8'h00;
    end else begin
      word_r    <= word_next_s;
      phase_r   <= phase_next_s;
      started_r <= started_next_s;
      strobe_r  <= strobe_next_s;
      byte_r    <= byte_next_s;
    end
  end

  assign uo_out   = byte_r;
  assign uio_out  = {5'b0_0000, strobe_r, 2'b00};
  assign uio_oe   = 8'b0000_0100;
  assign unused_s = &{1'b0, ena, ui_in[7:1], uio_in};

endmodule

// File: tb/tb_dsm_decimation_filter.sv
// Randomised and directed bench for dsm_decimation_filter against a sinc3
// impulse-response reference model.
module tb_dsm_decimation_filter;

  localparam int R = 256;
  localparam int K_ZERO = 0;
  localparam int K_ONES = 1;
  localparam int K_ALT  = 2;
  localparam int K_QUAD = 3;
  localparam int K_RAND = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'hA5;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  int          n_checks = 0;
  int          n_pass = 0;
  int          k = 0;
  int          first_strobe = -1;
  longint      cur_code = 0;
  logic [23:0] obs_code = 24'h0;
  bit          xs[$];
  logic [23:0] frame_codes[$];

  dsm_decimation_filter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, k);
  endtask

  function automatic longint c2(input longint n);
    return (n >= 2) ? n * (n - 1) / 2 : 64'd0;
  endfunction

  // Frame m output = sum of input bits weighted by the sinc3 kernel of the
  // window ending at the wrap; bit j is the input taken at edge j after release.
  function automatic longint model_code(input int m);
    longint acc = 0;
    longint base = longint'(m) * R - 1;
    int lo = (m - 3) * R;
    if (lo < 1) lo = 1;
    for (int j = lo; j <= m * R - 1; j++) begin
      if (xs[j-1])
        acc += c2(base - j) - 3 * c2(base - R - j) + 3 * c2(base - 2 * R - j) - c2(base - 3 * R - j);
    end
    if (acc >= 64'd16777216) acc = 64'hFFFFFF;
    return acc;
  endfunction

  task automatic do_reset(input int ncyc);
    rst_n = 1'b0;
    #1;
    check("rst_uo", 32'(uo_out), 32'h0);
    check("rst_uio", 32'(uio_out), 32'h0);
    check("rst_oe", 32'(uio_oe), 32'h4);
    repeat (ncyc) begin
      @(negedge clk);
      check("rst_uo", 32'(uo_out), 32'h0);
      check("rst_uio", 32'(uio_out), 32'h0);
      check("rst_oe", 32'(uio_oe), 32'h4);
    end
    xs.delete();
    frame_codes.delete();
    first_strobe = -1;
    cur_code = 0;
    k = 0;
    rst_n = 1'b1;
  endtask

  task automatic run_cycle(input bit b);
    int m;
    int n;
    logic [23:0] c;
    logic [7:0] exp_byte;
    logic exp_strobe;
    ui_in = {7'($urandom), b};
    @(posedge clk);
    xs.push_back(b);
    @(negedge clk);
    k = xs.size();
    m = k / R;
    n = k % R;
    if (m >= 1 && n == 0) cur_code = model_code(m);
    c = cur_code[23:0];
    exp_strobe = (m >= 1) && (n < 8);
    if (m == 0) exp_byte = 8'h00;
    else if (n <= 39) exp_byte = c[23:16];
    else if (n <= 55) exp_byte = c[15:8];
    else exp_byte = c[7:0];
    check("strobe", 32'(uio_out), 32'({5'b0, exp_strobe, 2'b0}));
    check("byte", 32'(uo_out), 32'(exp_byte));
    check("oe", 32'(uio_oe), 32'h4);
    if (uio_out[2] && first_strobe < 0) first_strobe = k;
    if (m >= 1 && n == 32) obs_code[23:16] = uo_out;
    if (m >= 1 && n == 48) obs_code[15:8] = uo_out;
    if (m >= 1 && n == 64) begin
      obs_code[7:0] = uo_out;
      frame_codes.push_back(obs_code);
    end
  endtask

  function automatic bit gen_bit(input int kind, input int j);
    case (kind)
      K_ZERO:  return 1'b0;
      K_ONES:  return 1'b1;
      K_ALT:   return (j % 2) == 1;
      K_QUAD:  return (j % 4) == 1;
      default: return 1'($urandom);
    endcase
  endfunction

  task automatic run_frames(input int kind, input int nframes);
    for (int i = 0; i < nframes * R + 65; i++)
      run_cycle(gen_bit(kind, xs.size() + 1));
    check("first_strobe", 32'(first_strobe), 32'd256);
  endtask

  initial begin
    @(negedge clk);

    // All zeros: every code is zero.
    do_reset(10);
    run_frames(K_ZERO, 5);
    for (int f = 1; f <= 5; f++) check("zeros_code", 32'(frame_codes[f-1]), 32'h0);

    // All ones: saturates from frame 3, first two frames rising below it.
    do_reset(4);
    run_frames(K_ONES, 5);
    check("ones_rise", 32'(frame_codes[0] < frame_codes[1] && frame_codes[1] < 24'hFFFFFF), 32'h1);
    for (int f = 3; f <= 5; f++) check("ones_code", 32'(frame_codes[f-1]), 32'hFFFFFF);

    do_reset(4);
    run_frames(K_ALT, 5);
    for (int f = 3; f <= 5; f++) check("alt_code", 32'(frame_codes[f-1]), 32'h800000);

    do_reset(4);
    run_frames(K_QUAD, 5);
    for (int f = 3; f <= 5; f++) check("quad_code", 32'(frame_codes[f-1]), 32'h400000);

    do_reset(4);
    run_frames(K_RAND, 4);

    // Reset while the middle byte is on the bus.
    do_reset(4);
    for (int i = 0; i < 2 * R + 45; i++) run_cycle(1'($urandom));
    check("midrst_phase", 32'(k % R), 32'd45);
    rst_n = 1'b0;
    #1;
    check("midrst_uo", 32'(uo_out), 32'h0);
    check("midrst_uio", 32'(uio_out), 32'h0);
    do_reset(5);
    run_frames(K_RAND, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
